turn_scheduler: RTL
===================

TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port game_start, input, 1, starts a game; honoured only in S_IDLE or S_OVER.
REQ-004 SHALL have port first_card, input, 6, initial discard; sampled with game_start.
REQ-005 SHALL have port turn_start, output, 4, one-hot one-cycle pulse telling player cur_player to act.
REQ-006 SHALL have port turn_done, input, 1, one-cycle pulse: current player finished its turn.
REQ-007 SHALL have port card_played, input, 1, qualifies turn_done: 1 = card discarded, 0 = player drew instead.
REQ-008 SHALL have port played_card, input, 6, discarded card, valid with turn_done & card_played; wilds carry the chosen colour.
REQ-009 SHALL have port hand_empty, input, 1, valid with turn_done: the player's hand is now empty.
REQ-010 SHALL have port top_card, output, 6, current discard.
REQ-011 SHALL have port draw_req, output, 1, request to deck for one penalty card; held until draw_ack.
REQ-012 SHALL have port draw_target, output, 2, player receiving the penalty card.
REQ-013 SHALL have port draw_ack, input, 1, deck delivered one card to draw_target.
REQ-014 SHALL have ports cur_player (output, 2, active player), direction (output, 1, 0 = ascending, 1 = descending), winner (output, 2, valid in S_OVER), game_over (output, 1, high in S_OVER).

Function
REQ-015 SHALL use card encoding: [5:4] colour (00 red, 01 yellow, 10 green, 11 blue); [3:0] value 0-9, 10 skip, 11 reverse, 12 draw-two, 13 wild, 14 wild-draw-four.
REQ-016 SHALL implement states S_IDLE, S_ISSUE, S_WAIT, S_DECODE, S_PENALTY, S_ADVANCE, S_OVER; all outputs registered or decoded from registered state.
REQ-017 S_IDLE/S_OVER + game_start: cur_player=0, direction=0, top_card=first_card, game_over=0 -> S_ISSUE; an action first_card has no effect.
REQ-018 S_ISSUE: turn_start[cur_player]=1 for exactly this cycle -> S_WAIT.
REQ-019 S_WAIT: holds until turn_done; turn_done in any other state is ignored.
REQ-020 On turn_done with card_played=1: top_card<=played_card; with card_played=0: top_card unchanged.
REQ-021 On turn_done with hand_empty=1 and card_played=1: winner<=cur_player -> S_OVER, card effect discarded; otherwise -> S_DECODE.
REQ-022 S_DECODE (1 cycle), on card just played: skip -> step 2; reverse -> direction toggles, step 1; draw-two -> pending 2; wild-draw-four -> pending 4; all others or no card -> step 1.
REQ-023 Penalty cards: victim = next player in (possibly updated) direction, step 2, -> S_PENALTY; otherwise -> S_ADVANCE.
REQ-024 S_PENALTY: draw_req=1, draw_target=victim; each draw_ack decrements pending (3-bit); ack at pending 1 -> S_ADVANCE with draw_req low the next cycle.
REQ-025 draw_ack while draw_req=0 SHALL be ignored.
REQ-026 S_ADVANCE: cur_player <= cur_player + step (direction 0) or - step (direction 1), modulo 4 via 2-bit wrap -> S_ISSUE.
REQ-027 Turn latency: turn_done to next turn_start = 3 cycles without penalty (DECODE, ADVANCE, ISSUE); penalty adds one cycle per draw beyond ack latency.
REQ-028 game_start outside S_IDLE/S_OVER SHALL be ignored.

Reset
REQ-029 reset SHALL force S_IDLE, turn_start=0, draw_req=0, draw_target=0, cur_player=0, direction=0, top_card=0, winner=0, game_over=0, pending=0, from any state including mid-penalty.

Structure
REQ-030 Card colour/value enums, state enum, and NUM_PLAYERS=4 SHALL live in shared package uno_pkg.
REQ-031 Next-player arithmetic (cur, step, direction -> player) SHALL be combinational sub-module uno_next_player, instanced for victim and advance.

Verification
REQ-032 game_start, first_card=6'h05; player 0 plays red 7 -> turn_start=4'b0010 exactly 3 cycles after turn_done.
REQ-033 cur_player=3, direction=0, plays skip -> cur_player=1 (wrap), no draw_req.
REQ-034 cur_player=1 plays reverse -> direction=1, cur_player=0; next reverse -> direction=0.
REQ-035 cur_player=0 plays wild-draw-four (6'h3E) -> draw_target=1, four draw_acks with gaps, draw_req drops after fourth, next turn_start=4'b0100, top_card=6'h3E.
REQ-036 turn_done+hand_empty on draw-two by player 2 -> game_over=1, winner=2, no draw_req; reset during S_PENALTY -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/uno_pkg.sv
// Shared card encoding, scheduler state encoding and player helpers for the
// UNO turn scheduler.
package uno_pkg;

    localparam int NUM_PLAYERS = 4;

    typedef enum logic [1:0] {
        C_RED    = 2'b00,
        C_YELLOW = 2'b01,
        C_GREEN  = 2'b10,
        C_BLUE   = 2'b11
    } colour_e;

    typedef enum logic [3:0] {
        V_0       = 4'd0,
        V_1       = 4'd1,
        V_2       = 4'd2,
        V_3       = 4'd3,
        V_4       = 4'd4,
        V_5       = 4'd5,
        V_6       = 4'd6,
        V_7       = 4'd7,
        V_8       = 4'd8,
        V_9       = 4'd9,
        V_SKIP    = 4'd10,
        V_REVERSE = 4'd11,
        V_DRAW2   = 4'd12,
        V_WILD    = 4'd13,
        V_WILD4   = 4'd14
    } value_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_DECODE  = 3'd3,
        S_PENALTY = 3'd4,
        S_ADVANCE = 3'd5,
        S_OVER    = 3'd6
    } state_e;

    function automatic value_e card_value(input logic [5:0] card);
        return value_e'(card[3:0]);
    endfunction

    function automatic logic [NUM_PLAYERS-1:0] player_onehot(input logic [1:0] player);
        logic [NUM_PLAYERS-1:0] v;
        v         = '0;
        v[player] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/uno_next_player.sv
// Seat arithmetic: the player 'step' seats away from 'cur' in the given
// direction; the 2-bit result wraps naturally around the four seats.
module uno_next_player
    import uno_pkg::*;
(
    input  logic [1:0] i_cur,
    input  logic [1:0] i_step,
    input  logic       i_dir,
    output logic [1:0] o_next
);

    assign o_next = i_dir ? (i_cur - i_step) : (i_cur + i_step);

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer for a four-player UNO table: issues turns, applies card
// effects and collects penalty cards from the deck before advancing.
//
// state     | meaning
// S_IDLE    | no game in progress, waiting for game_start
// S_ISSUE   | turn_start pulse for cur_player
// S_WAIT    | waiting for the active player's turn_done
// S_DECODE  | evaluate the card just played (step, direction, penalty)
// S_PENALTY | draw_req held to the deck until pending cards are acked
// S_ADVANCE | move cur_player by step in the current direction
// S_OVER    | a player emptied its hand; winner valid
module turn_scheduler
    import uno_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       game_start,
    input  logic [5:0] first_card,
    output logic [3:0] turn_start,
    input  logic       turn_done,
    input  logic       card_played,
    input  logic [5:0] played_card,
    input  logic       hand_empty,
    output logic [5:0] top_card,
    output logic       draw_req,
    output logic [1:0] draw_target,
    input  logic       draw_ack,
    output logic [1:0] cur_player,
    output logic       direction,
    output logic [1:0] winner,
    output logic       game_over
);

    state_e      r_state;
    logic [3:0]  r_turn_start;
    logic [5:0]  r_top_card;
    logic        r_draw_req;
    logic [1:0]  r_draw_target;
    logic [1:0]  r_cur_player;
    logic        r_direction;
    logic [1:0]  r_winner;
    logic        r_game_over;
    logic [2:0]  r_pending;
    logic [1:0]  r_step;
    logic        r_card_played;

    value_e      w_value;
    logic        w_is_skip;
    logic        w_is_reverse;
    logic        w_is_draw2;
    logic        w_is_wild4;
    logic        w_dec_penalty;
    logic        w_dec_dir;
    logic [1:0]  w_dec_step;
    logic [2:0]  w_dec_pending;
    logic [1:0]  w_victim;
    logic [1:0]  w_adv_player;

    // Card effects only apply when this turn actually discarded a card;
    // a draw leaves the previous (already resolved) top card in place.
    always_comb begin
        w_value       = card_value(r_top_card);
        w_is_skip     = r_card_played && (w_value == V_SKIP);
        w_is_reverse  = r_card_played && (w_value == V_REVERSE);
        w_is_draw2    = r_card_played && (w_value == V_DRAW2);
        w_is_wild4    = r_card_played && (w_value == V_WILD4);
        w_dec_penalty = w_is_draw2 || w_is_wild4;
        w_dec_dir     = r_direction ^ w_is_reverse;
        w_dec_step    = (w_is_skip || w_dec_penalty) ? 2'd2 : 2'd1;
        w_dec_pending = 3'd0;
        if (w_is_draw2) begin
            w_dec_pending = 3'd2;
        end else if (w_is_wild4) begin
            w_dec_pending = 3'd4;
        end
    end

    uno_next_player u_victim (
        .i_cur  (r_cur_player),
        .i_step (2'd1),
        .i_dir  (w_dec_dir),
        .o_next (w_victim)
    );

    uno_next_player u_advance (
        .i_cur  (r_cur_player),
        .i_step (r_step),
        .i_dir  (r_direction),
        .o_next (w_adv_player)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_turn_start  <= '0;
            r_top_card    <= '0;
            r_draw_req    <= 1'b0;
            r_draw_target <= '0;
            r_cur_player  <= '0;
            r_direction   <= 1'b0;
            r_winner      <= '0;
            r_game_over   <= 1'b0;
            r_pending     <= '0;
            r_step        <= 2'd1;
            r_card_played <= 1'b0;
        end else begin
            r_turn_start <= '0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (game_start) begin
                        r_cur_player  <= '0;
                        r_direction   <= 1'b0;
                        r_top_card    <= first_card;
                        r_game_over   <= 1'b0;
                        r_card_played <= 1'b0;
                        r_turn_start  <= player_onehot(2'd0);
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (turn_done) begin
                        r_card_played <= card_played;
                        if (card_played) begin
                            r_top_card <= played_card;
                        end
                        if (hand_empty && card_played) begin
                            r_winner    <= r_cur_player;
                            r_game_over <= 1'b1;
                            r_state     <= S_OVER;
                        end else begin
                            r_state <= S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    r_direction <= w_dec_dir;
                    r_step      <= w_dec_step;
                    if (w_dec_penalty) begin
                        r_pending     <= w_dec_pending;
                        r_draw_req    <= 1'b1;
                        r_draw_target <= w_victim;
                        r_state       <= S_PENALTY;
                    end else begin
                        r_state <= S_ADVANCE;
                    end
                end
                S_PENALTY: begin
                    if (draw_ack && r_draw_req) begin
                        r_pending <= r_pending - 3'd1;
                        if (r_pending == 3'd1) begin
                            r_draw_req <= 1'b0;
                            r_state    <= S_ADVANCE;
                        end
                    end
                end
                S_ADVANCE: begin
                    r_cur_player <= w_adv_player;
                    r_turn_start <= player_onehot(w_adv_player);
                    r_state      <= S_ISSUE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign turn_start  = r_turn_start;
    assign top_card    = r_top_card;
    assign draw_req    = r_draw_req;
    assign draw_target = r_draw_target;
    assign cur_player  = r_cur_player;
    assign direction   = r_direction;
    assign winner      = r_winner;
    assign game_over   = r_game_over;

endmodule
